// File: rtl/jtframe_db15_reader.sv
// DB15 adapter reader: scans a 74HC165 chain over JOY_LOAD/JOY_CLK/JOY_DATA and publishes two
// active-high joystick words once two consecutive scans agree.
module jtframe_db15_reader #(
    parameter int unsigned CLKDIV  = 24,
    parameter int unsigned NBITS   = 24,
    parameter int unsigned PERBITS = 12,
    parameter int unsigned GAP     = 16
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    input  logic        JOY_DATA,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        joy_upd
);

    localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSamp,
        StRise,
        StDone,
        StGap
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_div;
    logic [BW-1:0]    r_bit;
    logic [GW-1:0]    r_gap;
    logic [1:0]       r_sync;
    logic [NBITS-1:0] r_raw;
    logic [NBITS-1:0] r_prev;
    logic             w_tick;
    logic             w_last_bit;

    assign w_tick     = (r_div == DW'(CLKDIV - 1));
    assign w_last_bit = (r_bit == BW'(NBITS - 1));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Chain output idles high, so the synchroniser resets to "no button pressed".
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], JOY_DATA};
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_bit     <= '0;
            r_gap     <= '0;
            r_raw     <= '0;
            r_prev    <= '0;
            JOY_CLK   <= 1'b0;
            JOY_LOAD  <= 1'b1;
            joystick1 <= '0;
            joystick2 <= '0;
            joy_upd   <= 1'b0;
        end else begin
            joy_upd <= 1'b0;
            if (!enable) begin
                // Abort is immediate; clearing prev forces two fresh scans after re-enable.
                r_state  <= StIdle;
                r_bit    <= '0;
                r_prev   <= '0;
                JOY_CLK  <= 1'b0;
                JOY_LOAD <= 1'b1;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_tick) begin
                            r_state  <= StLoad;
                            JOY_LOAD <= 1'b0;
                        end
                    end
                    StLoad: begin
                        if (w_tick) begin
                            r_state  <= StSamp;
                            r_bit    <= '0;
                            JOY_LOAD <= 1'b1;
                        end
                    end
                    StSamp: begin
                        if (w_tick) begin
                            r_raw[r_bit] <= ~r_sync[1];
                            JOY_CLK      <= 1'b1;
                            r_state      <= StRise;
                        end
                    end
                    StRise: begin
                        if (w_tick) begin
                            JOY_CLK <= 1'b0;
                            if (w_last_bit) begin
                                r_state <= StDone;
                            end else begin
                                r_bit   <= r_bit + 1'b1;
                                r_state <= StSamp;
                            end
                        end
                    end
                    StDone: begin
                        // Single-cycle filter step; not tick-gated so it does not lengthen the scan.
                        if (r_raw == r_prev) begin
                            joystick1 <= 16'(r_raw[PERBITS-1:0]);
                            joystick2 <= 16'(r_raw[2*PERBITS-1:PERBITS]);
                            joy_upd   <= 1'b1;
                        end
                        r_prev  <= r_raw;
                        r_gap   <= '0;
                        r_state <= StGap;
                    end
                    StGap: begin
                        if (w_tick) begin
                            if (r_gap == GW'(GAP - 1)) begin
                                r_state  <= StLoad;
                                JOY_LOAD <= 1'b0;
                            end else begin
                                r_gap <= r_gap + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_db15_reader.sv
// Bench for jtframe_db15_reader: a behavioural 74HC165 chain plus a scoreboard of expected
// joystick updates, checked by an independent monitor on every joy_upd pulse.
module tb_jtframe_db15_reader;

    localparam int unsigned NBITS   = 24;
    localparam int unsigned PERBITS = 12;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        joy_upd;

    jtframe_db15_reader dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .enable    (enable),
        .JOY_CLK   (JOY_CLK),
        .JOY_LOAD  (JOY_LOAD),
        .JOY_DATA  (JOY_DATA),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .joy_upd   (joy_upd)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [15:0] j1;
        logic [15:0] j2;
    } exp_t;

    exp_t             q[$];
    int               checks   = 0;
    int               failures = 0;
    int               cyc      = 0;
    int               scans_done = 0;
    int               upd_cnt  = 0;
    int               idx      = 0;
    int               rises    = 0;
    bit               scanning = 1'b0;
    logic             prev_clk = 1'b0;
    logic [NBITS-1:0] pat      = '0;
    logic [NBITS-1:0] latched  = '0;
    logic [NBITS-1:0] model_prev = '0;
    logic [NBITS-1:0] lmask    = NBITS'((1 << PERBITS) - 1);
    exp_t             held     = '0;

    // Pressed buttons pull their chain bit low; past the end of the chain the serial input reads high.
    assign JOY_DATA = (idx < int'(NBITS)) ? ~latched[idx] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [NBITS-1:0] v);
        exp_t e;
        e.j1 = 16'(v & lmask);
        e.j2 = 16'((v >> PERBITS) & lmask);
        return e;
    endfunction

    always @(posedge clk_sys) cyc++;

    // Chain model: latch on LOAD, advance one bit per JOY_CLK rising edge, score each full scan.
    initial forever begin
        @(negedge clk_sys);
        if (!rst_n) begin
            idx = 0; rises = 0; scanning = 1'b0; model_prev = '0; latched = '0;
            q.delete();
        end else if (!enable) begin
            scanning = 1'b0; model_prev = '0;
        end else if (!JOY_LOAD) begin
            latched = pat; idx = 0; rises = 0; scanning = 1'b1;
        end else if (JOY_CLK && !prev_clk && scanning) begin
            rises++; idx++;
            if (rises == int'(NBITS)) begin
                if (latched == model_prev) q.push_back(expect_of(latched));
                model_prev = latched;
                scanning = 1'b0;
                scans_done++;
            end
        end
        prev_clk = JOY_CLK;
    end

    // Monitor: every pulse must match the oldest expected update; otherwise outputs must hold.
    initial forever begin
        @(negedge clk_sys);
        if (!rst_n) begin
            held = '0;
            check("reset_outputs", {joystick1, joystick2}, 32'(held));
        end else if (joy_upd) begin
            check("upd_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                held = q.pop_front();
                check("upd_joystick1", 32'(joystick1), 32'(held.j1));
                check("upd_joystick2", 32'(joystick2), 32'(held.j2));
            end
            upd_cnt++;
        end else begin
            check("hold_outputs", {joystick1, joystick2}, 32'(held));
        end
    end

    task automatic wait_scans(input int n);
        int target = scans_done + n;
        int budget = 0;
        while (scans_done < target && budget < n * 2000 + 2000) begin
            @(negedge clk_sys);
            budget++;
        end
        check("scan_timeout", 32'(scans_done >= target), 32'd1);
    endtask

    initial begin
        int n, low, nr, r1, r2, t0, u0, act;
        logic [NBITS-1:0] pat_new;
        exp_t e;

        // Reset and long idle with scanning disabled.
        rst_n = 1'b0; enable = 1'b0;
        repeat (5) @(negedge clk_sys);
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_sys);
            if (!JOY_LOAD || JOY_CLK || joy_upd) act++;
        end
        check("idle_activity", 32'(act), 32'd0);
        check("idle_load", 32'(JOY_LOAD), 32'd1);
        check("idle_clk", 32'(JOY_CLK), 32'd0);
        check("idle_joy", {joystick1, joystick2}, 32'd0);

        // Scan timing.
        enable = 1'b1;
        n = 0;
        while (JOY_LOAD && n < 200) begin @(negedge clk_sys); n++; end
        check("load_start", 32'(n < 200), 32'd1);
        t0 = cyc; low = 0;
        while (!JOY_LOAD && low < 100) begin @(negedge clk_sys); low++; end
        check("load_low_cycles", 32'(low), 32'd24);
        nr = 0; r1 = 0; r2 = 0; n = 0;
        prev_clk_loop: while (JOY_LOAD && n < 3000) begin
            logic pc;
            pc = JOY_CLK;
            @(negedge clk_sys); n++;
            if (JOY_CLK && !pc) begin
                nr++;
                if (nr == 1) r1 = cyc;
                if (nr == 2) r2 = cyc;
            end
        end
        check("clk_rises_per_scan", 32'(nr), 32'd24);
        check("clk_period", 32'(r2 - r1), 32'd48);
        check("load_to_load", 32'(cyc - t0), 32'd1560);

        // Mapping: bit0 and bit13 pressed.
        wait_scans(1);
        pat = NBITS'(24'h002001);
        wait_scans(2);
        repeat (40) @(negedge clk_sys);
        check("map_joystick1", 32'(joystick1), 32'h0001);
        check("map_joystick2", 32'(joystick2), 32'h0002);
        u0 = upd_cnt;
        wait_scans(2);
        repeat (40) @(negedge clk_sys);
        check("upd_per_scan", 32'(upd_cnt - u0), 32'd2);

        // Single-scan glitch on bit5 must not reach the outputs.
        pat = '0;
        wait_scans(3);
        pat = NBITS'(24'h000020);
        wait_scans(1);
        pat = '0;
        wait_scans(3);
        repeat (40) @(negedge clk_sys);
        check("glitch_joystick1", 32'(joystick1), 32'h0000);

        // Randomised patterns held for one or two scans.
        for (int i = 0; i < 5; i++) begin
            pat = NBITS'($urandom);
            wait_scans(int'($urandom_range(1, 2)));
        end

        // Abort at bit 10 with a new pattern, then re-enable.
        wait_scans(1);
        pat_new = (pat ^ NBITS'(24'h000801)) | NBITS'(24'h000100);
        pat = pat_new;
        e = expect_of(pat_new);
        n = 0;
        while (!(scanning && rises == 10) && n < 3000) begin @(negedge clk_sys); n++; end
        check("abort_reach_bit10", 32'(n < 3000), 32'd1);
        enable = 1'b0;
        @(negedge clk_sys);
        check("abort_clk", 32'(JOY_CLK), 32'd0);
        check("abort_load", 32'(JOY_LOAD), 32'd1);
        repeat (100) @(negedge clk_sys);
        check("abort_hold", {joystick1, joystick2}, 32'(held));
        enable = 1'b1;
        wait_scans(1);
        repeat (40) @(negedge clk_sys);
        check("reenable_first_scan", {joystick1, joystick2}, 32'(held));
        wait_scans(1);
        repeat (40) @(negedge clk_sys);
        check("reenable_joystick1", 32'(joystick1), 32'(e.j1));
        check("reenable_joystick2", 32'(joystick2), 32'(e.j2));

        // Asynchronous reset in the middle of a SAMP phase.
        n = 0;
        while (!(scanning && rises == 5 && JOY_LOAD && !JOY_CLK) && n < 3000) begin
            @(negedge clk_sys); n++;
        end
        check("reset_reach_samp", 32'(n < 3000), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_joy", {joystick1, joystick2}, 32'd0);
        check("async_reset_load", 32'(JOY_LOAD), 32'd1);
        check("async_reset_clk", 32'(JOY_CLK), 32'd0);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        n = 0;
        while (JOY_LOAD && !JOY_CLK && n < 200) begin @(negedge clk_sys); n++; end
        check("restart_with_load", {30'd0, JOY_LOAD, JOY_CLK}, 32'd0);
        wait_scans(2);
        repeat (40) @(negedge clk_sys);
        check("post_reset_joystick1", 32'(joystick1), 32'(e.j1));
        check("post_reset_joystick2", 32'(joystick2), 32'(e.j2));
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
